// File: rtl/eth_rx_frame_buffer_pkg.sv
// Shared types for the Rx store-and-forward frame buffer: RAM entry layout,
// write-side FSM states and the pointer width helper.
package eth_rx_frame_buffer_pkg;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  typedef enum logic {
    PASS = 1'b0,
    DROP = 1'b1
  } wr_state_t;

  // One extra bit distinguishes full from empty when the addresses match.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/eth_rx_frame_buffer_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// read, written so that synthesis maps it onto block RAM.
module eth_rx_frame_buffer_sdp_ram #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 512,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/eth_rx_frame_buffer.sv
// Store-and-forward Rx frame buffer: keeps only good-CRC frames, drops bad
// and overflowed ones, and folds zero-keep tlast beats into the prior word.
module eth_rx_frame_buffer
  import eth_rx_frame_buffer_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      s00_axis_tdata,
  input  logic [3:0]       s00_axis_tkeep,
  input  logic             s00_axis_tvalid,
  input  logic             s00_axis_tlast,
  input  logic             s00_axis_tuser,
  output logic [31:0]      m00_axis_tdata,
  output logic [3:0]       m00_axis_tkeep,
  output logic             m00_axis_tvalid,
  input  logic             m00_axis_tready,
  output logic             m00_axis_tlast,
  output logic [CNT_W-1:0] o_drop_crc,
  output logic [CNT_W-1:0] o_drop_ovf
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] PTR_DEPTH = PW'(DEPTH);

  wr_state_t        state_reg, state_next;
  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    wr_commit_reg, wr_commit_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  entry_t           pend_reg, pend_next;
  logic             pend_valid_reg, pend_valid_next;
  logic             pend_flush_reg, pend_flush_next;
  logic [CNT_W-1:0] drop_crc_reg, drop_crc_next;
  logic [CNT_W-1:0] drop_ovf_reg, drop_ovf_next;

  logic             full;
  logic             cur_pend;
  logic             crc_inc;
  logic [1:0]       ovf_inc;
  logic [CNT_W:0]   ovf_sum;
  logic             ram_we;
  entry_t           ram_wdata;
  entry_t           ram_rdata;

  logic             rd_en;
  logic             rd_valid_reg;
  entry_t           skid0_reg, skid0_next;
  entry_t           skid1_reg, skid1_next;
  logic [1:0]       skid_cnt_reg, skid_cnt_next;
  logic [1:0]       held;
  logic             out_valid;
  entry_t           out_entry;
  logic             pop;
  logic             pop_skid;
  logic             push;

  assign full = (wr_ptr_reg - rd_ptr_reg) == PTR_DEPTH;

  // Write side. A flush of the previous frame's last word is resolved first,
  // so a bad or empty frame arriving in the same cycle rolls back onto the
  // freshly committed pointer.
  always_comb begin
    state_next      = state_reg;
    wr_ptr_next     = wr_ptr_reg;
    wr_commit_next  = wr_commit_reg;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
    pend_flush_next = pend_flush_reg;
    ram_we          = 1'b0;
    ram_wdata       = pend_reg;
    crc_inc         = 1'b0;
    ovf_inc         = 2'd0;
    cur_pend        = pend_valid_reg && !pend_flush_reg;

    if (pend_valid_reg && pend_flush_reg) begin
      pend_valid_next = 1'b0;
      pend_flush_next = 1'b0;
      if (full) begin
        ovf_inc     = ovf_inc + 2'd1;
        wr_ptr_next = wr_commit_reg;
      end else begin
        ram_we         = 1'b1;
        wr_ptr_next    = wr_ptr_reg + 1'b1;
        wr_commit_next = wr_ptr_reg + 1'b1;
      end
    end

    if (s00_axis_tvalid) begin
      if (state_reg == DROP) begin
        if (s00_axis_tlast) begin
          wr_ptr_next = wr_commit_next;
          ovf_inc     = ovf_inc + 2'd1;
          state_next  = PASS;
        end
      end else if (!s00_axis_tlast || s00_axis_tkeep != 4'd0) begin
        if (cur_pend && full) begin
          pend_valid_next = 1'b0;
          if (s00_axis_tlast) begin
            wr_ptr_next = wr_commit_next;
            ovf_inc     = ovf_inc + 2'd1;
          end else begin
            state_next = DROP;
          end
        end else begin
          if (cur_pend) begin
            ram_we      = 1'b1;
            wr_ptr_next = wr_ptr_reg + 1'b1;
          end
          if (s00_axis_tlast && !s00_axis_tuser) begin
            crc_inc         = 1'b1;
            wr_ptr_next     = wr_commit_next;
            pend_valid_next = 1'b0;
          end else begin
            pend_next       = '{data: s00_axis_tdata, keep: s00_axis_tkeep, last: s00_axis_tlast};
            pend_valid_next = 1'b1;
            pend_flush_next = s00_axis_tlast;
          end
        end
      end else begin
        // Zero-keep tlast: the pending word becomes the frame's last word now.
        if (!cur_pend) begin
          ovf_inc = ovf_inc + 2'd1;
        end else if (!s00_axis_tuser) begin
          crc_inc         = 1'b1;
          wr_ptr_next     = wr_commit_next;
          pend_valid_next = 1'b0;
        end else if (full) begin
          ovf_inc         = ovf_inc + 2'd1;
          wr_ptr_next     = wr_commit_next;
          pend_valid_next = 1'b0;
        end else begin
          ram_we          = 1'b1;
          ram_wdata.last  = 1'b1;
          wr_ptr_next     = wr_ptr_reg + 1'b1;
          wr_commit_next  = wr_ptr_reg + 1'b1;
          pend_valid_next = 1'b0;
        end
      end
    end
  end

  always_comb begin
    drop_crc_next = (crc_inc && drop_crc_reg != '1) ? drop_crc_reg + 1'b1 : drop_crc_reg;
    ovf_sum       = {1'b0, drop_ovf_reg} + (CNT_W+1)'(ovf_inc);
    drop_ovf_next = ovf_sum[CNT_W] ? '1 : ovf_sum[CNT_W-1:0];
  end

  eth_rx_frame_buffer_sdp_ram #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (i_clk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr_reg[AW-1:0]),
    .wr_data (ram_wdata),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_reg[AW-1:0]),
    .rd_data (ram_rdata)
  );

  // Read side. The RAM output register acts as the head when the skid is
  // empty; a new read is issued only if its word is sure to have a slot.
  always_comb begin
    held      = skid_cnt_reg + {1'b0, rd_valid_reg};
    out_valid = (skid_cnt_reg != 2'd0) || rd_valid_reg;
    out_entry = (skid_cnt_reg != 2'd0) ? skid0_reg : ram_rdata;
    pop       = out_valid && m00_axis_tready;
    rd_en     = (rd_ptr_reg != wr_commit_reg) && ((held - {1'b0, pop}) < 2'd2);
    rd_ptr_next = rd_ptr_reg + PW'(rd_en);

    pop_skid      = pop && (skid_cnt_reg != 2'd0);
    push          = rd_valid_reg && !(pop && skid_cnt_reg == 2'd0);
    skid0_next    = pop_skid ? skid1_reg : skid0_reg;
    skid1_next    = skid1_reg;
    skid_cnt_next = skid_cnt_reg - 2'(pop_skid);
    if (push) begin
      if (skid_cnt_next == 2'd0) begin
        skid0_next = ram_rdata;
      end else begin
        skid1_next = ram_rdata;
      end
      skid_cnt_next = skid_cnt_next + 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg      <= PASS;
      wr_ptr_reg     <= '0;
      wr_commit_reg  <= '0;
      rd_ptr_reg     <= '0;
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      pend_flush_reg <= 1'b0;
      drop_crc_reg   <= '0;
      drop_ovf_reg   <= '0;
      rd_valid_reg   <= 1'b0;
      skid0_reg      <= '0;
      skid1_reg      <= '0;
      skid_cnt_reg   <= 2'd0;
    end else begin
      state_reg      <= state_next;
      wr_ptr_reg     <= wr_ptr_next;
      wr_commit_reg  <= wr_commit_next;
      rd_ptr_reg     <= rd_ptr_next;
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
      pend_flush_reg <= pend_flush_next;
      drop_crc_reg   <= drop_crc_next;
      drop_ovf_reg   <= drop_ovf_next;
      rd_valid_reg   <= rd_en;
      skid0_reg      <= skid0_next;
      skid1_reg      <= skid1_next;
      skid_cnt_reg   <= skid_cnt_next;
    end
  end

  // Gate payload so an idle or freshly reset port shows all zeros.
  assign m00_axis_tvalid = out_valid;
  assign m00_axis_tdata  = out_valid ? out_entry.data : 32'd0;
  assign m00_axis_tkeep  = out_valid ? out_entry.keep : 4'd0;
  assign m00_axis_tlast  = out_valid ? out_entry.last : 1'b0;
  assign o_drop_crc      = drop_crc_reg;
  assign o_drop_ovf      = drop_ovf_reg;

endmodule
